// File: rtl/date_pkg.sv
// Shared widths, month/weekday encodings and the test preset date for the calendar stage.
package date_pkg;

    localparam int YEAR_W  = 7;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int WDAY_W  = 3;

    typedef enum logic [WDAY_W-1:0] {
        SUN = 3'd0, MON = 3'd1, TUE = 3'd2, WED = 3'd3,
        THU = 3'd4, FRI = 3'd5, SAT = 3'd6
    } weekday_e;

    typedef enum logic [MONTH_W-1:0] {
        JAN = 4'd1, FEB = 4'd2,  MAR = 4'd3,  APR = 4'd4,
        MAY = 4'd5, JUN = 4'd6,  JUL = 4'd7,  AUG = 4'd8,
        SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12
    } month_e;

    // Year is stored as an offset from 2000, so 99 is the last representable year.
    localparam logic [YEAR_W-1:0]  YEAR_MAX     = 7'd99;

    localparam logic [YEAR_W-1:0]  PRESET_YEAR  = 7'd24;
    localparam logic [MONTH_W-1:0] PRESET_MONTH = FEB;
    localparam logic [DAY_W-1:0]   PRESET_DAY   = 5'd28;
    localparam logic [WDAY_W-1:0]  PRESET_WDAY  = WED;

endpackage

// File: rtl/date_counter_days_in_month.sv
// Combinational month-length lookup; leap only affects February.
module days_in_month
    import date_pkg::*;
(
    input  logic [MONTH_W-1:0] month,
    input  logic               leap,
    output logic [DAY_W-1:0]   dim
);

    always_comb begin
        dim = 5'd31;
        case (month)
            FEB:                dim = leap ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: dim = 5'd30;
            default:            dim = 5'd31;
        endcase
    end

endmodule

// File: rtl/date_counter.sv
// Calendar counter (year 2000-2099, month, day, weekday) advanced by the time-of-day day flag.
// Leap-year February is enabled by defining DATE_LEAP_YEAR_EN; otherwise February is always 28 days.
module date_counter
    import date_pkg::*;
#(
    parameter int RESET_YEAR    = 0,
    parameter int RESET_MONTH   = 1,
    parameter int RESET_DAY     = 1,
    parameter int RESET_WEEKDAY = 6
) (
    input  logic               clk_1Hz,
    input  logic               rst_n,
    input  logic               day_increment,
    input  logic               set_en,
    input  logic               inc_day,
    input  logic               inc_month,
    input  logic               inc_year,
    input  logic               inc_wday,
    input  logic               preset,
    output logic [YEAR_W-1:0]  year,
    output logic [MONTH_W-1:0] month,
    output logic [DAY_W-1:0]   day,
    output logic [WDAY_W-1:0]  weekday,
    output logic               leap_year,
    output logic               year_wrap
);

    logic                day_inc_q;
    logic                advance;
    logic                leap_adj;
    logic [DAY_W-1:0]    dim_cur;
    logic [DAY_W-1:0]    dim_adj;
    logic [YEAR_W-1:0]   year_next;
    logic [MONTH_W-1:0]  month_next;
    logic [WDAY_W-1:0]   wday_next;
    logic [YEAR_W-1:0]   year_adj;
    logic [MONTH_W-1:0]  month_adj;
    logic [DAY_W-1:0]    day_step;
    logic [DAY_W-1:0]    day_adj;
    logic [WDAY_W-1:0]   wday_adj;

`ifdef DATE_LEAP_YEAR_EN
    // Every year divisible by 4 in 2000-2099 is a leap year (2000 included).
    assign leap_year = (year[1:0] == 2'b00);
    assign leap_adj  = (year_adj[1:0] == 2'b00);
`else
    assign leap_year = 1'b0;
    assign leap_adj  = 1'b0;
`endif

    days_in_month u_dim_cur (
        .month (month),
        .leap  (leap_year),
        .dim   (dim_cur)
    );

    days_in_month u_dim_adj (
        .month (month_adj),
        .leap  (leap_adj),
        .dim   (dim_adj)
    );

    assign advance = day_increment && !day_inc_q;

    always_comb begin
        year_next  = (year == YEAR_MAX) ? '0 : year + 1'b1;
        month_next = (month == MONTH_W'(DEC)) ? MONTH_W'(JAN) : month + 1'b1;
        wday_next  = (weekday == WDAY_W'(SAT)) ? WDAY_W'(SUN) : weekday + 1'b1;

        year_adj  = inc_year  ? year_next  : year;
        month_adj = inc_month ? month_next : month;
        wday_adj  = inc_wday  ? wday_next  : weekday;
        day_step  = day;
        if (inc_day) begin
            day_step = (day >= dim_cur) ? 5'd1 : day + 1'b1;
        end
        // Clamp so a month/year change in adjust mode can never leave e.g. 31 Feb.
        day_adj = (day_step > dim_adj) ? dim_adj : day_step;
    end

    always_ff @(posedge clk_1Hz) begin
        if (!rst_n) begin
            year      <= YEAR_W'(RESET_YEAR);
            month     <= MONTH_W'(RESET_MONTH);
            day       <= DAY_W'(RESET_DAY);
            weekday   <= WDAY_W'(RESET_WEEKDAY);
            year_wrap <= 1'b0;
            day_inc_q <= 1'b1;
        end else begin
            day_inc_q <= day_increment;
            year_wrap <= 1'b0;
            if (set_en) begin
                year    <= year_adj;
                month   <= month_adj;
                day     <= day_adj;
                weekday <= wday_adj;
            end else if (preset) begin
                year    <= PRESET_YEAR;
                month   <= PRESET_MONTH;
                day     <= PRESET_DAY;
                weekday <= PRESET_WDAY;
            end else if (advance) begin
                weekday <= wday_next;
                if (day < dim_cur) begin
                    day <= day + 1'b1;
                end else begin
                    day   <= 5'd1;
                    month <= month_next;
                    if (month == MONTH_W'(DEC)) begin
                        year      <= year_next;
                        year_wrap <= (year == YEAR_MAX);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_date_counter.sv
// Randomized + directed bench for date_counter with a field-level calendar model and scoreboard.
module tb_date_counter;

    logic       clk_1Hz;
    logic       rst_n;
    logic       day_increment;
    logic       set_en;
    logic       inc_day;
    logic       inc_month;
    logic       inc_year;
    logic       inc_wday;
    logic       preset;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic [2:0] weekday;
    logic       leap_year;
    logic       year_wrap;

    date_counter dut (
        .clk_1Hz       (clk_1Hz),
        .rst_n         (rst_n),
        .day_increment (day_increment),
        .set_en        (set_en),
        .inc_day       (inc_day),
        .inc_month     (inc_month),
        .inc_year      (inc_year),
        .inc_wday      (inc_wday),
        .preset        (preset),
        .year          (year),
        .month         (month),
        .day           (day),
        .weekday       (weekday),
        .leap_year     (leap_year),
        .year_wrap     (year_wrap)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    int total = 0;
    int bad   = 0;
    logic [20:0] expq[$];

    // Reference calendar state
    int my, mm, md, mw;
    bit mwrap, mprev;

    function automatic bit leap_of(input int y);
`ifdef DATE_LEAP_YEAR_EN
        return (y % 4) == 0;
`else
        return (y < 0);
`endif
    endfunction

    function automatic int dim_of(input int m, input int y);
        int t[12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && leap_of(y)) return 29;
        return t[m-1];
    endfunction

    function automatic logic [20:0] model_pack();
        return {7'(my), 4'(mm), 5'(md), 3'(mw), leap_of(my), mwrap};
    endfunction

    task automatic model_edge(input bit r, input bit dinc, input bit s, input bit id,
                              input bit im, input bit iy, input bit iw, input bit p);
        bit ev;
        int d2;
        if (!r) begin
            my = 0; mm = 1; md = 1; mw = 6; mwrap = 0; mprev = 1;
            return;
        end
        ev    = dinc && !mprev;
        mprev = dinc;
        mwrap = 0;
        if (s) begin
            d2 = md;
            if (id) d2 = (md == dim_of(mm, my)) ? 1 : md + 1;
            if (im) mm = (mm % 12) + 1;
            if (iy) my = (my + 1) % 100;
            if (iw) mw = (mw + 1) % 7;
            md = (d2 > dim_of(mm, my)) ? dim_of(mm, my) : d2;
        end else if (p) begin
            my = 24; mm = 2; md = 28; mw = 3;
        end else if (ev) begin
            mw = (mw + 1) % 7;
            md = md + 1;
            if (md > dim_of(mm, my)) begin
                md = 1;
                mm = mm + 1;
                if (mm > 12) begin
                    mm = 1;
                    my = my + 1;
                    if (my > 99) begin
                        my = 0;
                        mwrap = 1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit dinc, input bit s, input bit id,
                        input bit im, input bit iy, input bit iw, input bit p);
        rst_n = r; day_increment = dinc; set_en = s;
        inc_day = id; inc_month = im; inc_year = iy; inc_wday = iw; preset = p;
        @(posedge clk_1Hz);
        model_edge(r, dinc, s, id, im, iy, iw, p);
        #1;
        expq.push_back(model_pack());
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pulse();
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle();
    endtask

    task automatic adjust_to(input int y, input int m, input int d, input int w);
        int g;
        g = 0; while (my != y && g < 110) begin step(1, 0, 1, 0, 0, 1, 0, 0); g++; end
        g = 0; while (mm != m && g < 14)  begin step(1, 0, 1, 0, 1, 0, 0, 0); g++; end
        g = 0; while (md != d && g < 33)  begin step(1, 0, 1, 1, 0, 0, 0, 0); g++; end
        g = 0; while (mw != w && g < 8)   begin step(1, 0, 1, 0, 0, 0, 1, 0); g++; end
    endtask

    // Monitor: registered outputs are presented every cycle; compare mid-cycle.
    initial begin
        logic [20:0] e, a;
        forever begin
            @(negedge clk_1Hz);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = {year, month, day, weekday, leap_year, year_wrap};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL date @%0t: got y=%0d m=%0d d=%0d w=%0d leap=%0b wrap=%0b, want y=%0d m=%0d d=%0d w=%0d leap=%0b wrap=%0b",
                             $time, a[20:14], a[13:10], a[9:5], a[4:2], a[1], a[0],
                             e[20:14], e[13:10], e[9:5], e[4:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        bit dprev;
        rst_n = 0; day_increment = 0; set_en = 0; inc_day = 0;
        inc_month = 0; inc_year = 0; inc_wday = 0; preset = 0;
        my = 0; mm = 1; md = 1; mw = 6; mwrap = 0; mprev = 1;

        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(); idle();

        // 1 Jan -> 31 Jan, then into February
        repeat (30) pulse();
        pulse();

        // Test preset then one advance
        step(1, 0, 0, 0, 0, 0, 0, 1);
        pulse();

        // Century wrap
        adjust_to(99, 12, 31, 4);
        idle();
        pulse();
        idle(); idle();

        // Held level advances only once
        adjust_to(my, 3, 10, mw);
        idle();
        repeat (5) step(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) idle();

        // Day clamp on month change
        adjust_to(24, 1, 31, mw);
        step(1, 0, 1, 0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 0, 0, 0);
        idle();

        // Edge during adjust/preset is lost
        step(1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 1);
        idle();

        // Reset mid-adjust, then a level already high at release
        step(0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle();
        pulse();

        dprev = 0;
        repeat (3000) begin
            bit r, s, p, dinc;
            r = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 39) == 0);
            dinc = ($urandom_range(0, 2) == 0) ? ~dprev : dprev;
            dprev = dinc;
            step(r, dinc, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p);
        end

        repeat (3) @(negedge clk_1Hz);
        #1;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/date_counter.md
# date_counter

Calendar stage directly downstream of the time-of-day counter. It consumes that counter's `day_increment` flag and maintains year (2000–2099), month, day-of-month and weekday. It supports manual adjustment and a test preset using the same switch style as the time counter. All outputs are registered and feed the display multiplexer alongside hours, minutes and seconds.

## Interface
- `RESET_YEAR`, default 0: year offset from 2000 loaded at reset (0–99).
- `RESET_MONTH`, default 1: month loaded at reset (1–12).
- `RESET_DAY`, default 1: day loaded at reset; must be valid for `RESET_MONTH`.
- `RESET_WEEKDAY`, default 6: weekday at reset (0=Sun … 6=Sat; 1 Jan 2000 = Sat).
- `clk_1Hz`, in, 1: the only clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `day_increment`, in, 1: day-advance request from the time counter; may be held high for several cycles.
- `set_en`, in, 1: adjust mode; normal advance is suppressed while high.
- `inc_day`, in, 1: in adjust mode, +1 day per cycle.
- `inc_month`, in, 1: in adjust mode, +1 month per cycle.
- `inc_year`, in, 1: in adjust mode, +1 year per cycle.
- `inc_wday`, in, 1: in adjust mode, +1 weekday per cycle.
- `preset`, in, 1: loads the test date.
- `year`, out, 7: 0–99, where 0 means 2000.
- `month`, out, 4: 1–12.
- `day`, out, 5: 1–31.
- `weekday`, out, 3: 0–6.
- `leap_year`, out, 1: current year is a leap year.
- `year_wrap`, out, 1: one-cycle pulse on the 2099-12-31 → 2000-01-01 transition.

## Operation
- Priority per cycle: reset > `set_en` > `preset` > normal advance.
- Edge detect:
  - Register `day_inc_q` holds the previous-cycle value of `day_increment`.
  - An advance event is `day_increment && !day_inc_q`.
  - `day_inc_q` resets to 1, so a level that is already high at reset release does not advance the date.
  - `day_inc_q` updates every cycle in every mode.
- Normal advance:
  - If `day < dim(month, year)`, then `day + 1`.
  - Otherwise `day` becomes 1 and `month` advances; month 12 wraps to 1 and `year` advances; year 99 wraps to 0 and `year_wrap` is asserted.
  - `weekday` advances with every event, wrapping 6 → 0.
- Adjust (`set_en` = 1):
  - Each `inc_*` acts independently and wraps with no carry: day to 1 past `dim`, month 12 → 1, year 99 → 0, weekday 6 → 0.
  - Several `inc_*` may be high together; all are applied in the same cycle.
  - `inc_day` wraps against `dim` of the current month/year.
  - After the update, `day` is clamped to `dim(new month, new year)`. Registered outputs are never an invalid date.
  - Adjust mode never asserts `year_wrap`.
- Preset (`set_en` = 0): load year 24, month 2, day 28, weekday 3 (Wed 28 Feb 2024).
- `dim` is 31/28/31/30/31/30/31/31/30/31/30/31. February is 29 when `leap_year` is set.
- `leap_year = (year[1:0] == 0)`; this is exact for 2000–2099.

## Timing
- Reset values: `year` = `RESET_YEAR`, `month` = `RESET_MONTH`, `day` = `RESET_DAY`, `weekday` = `RESET_WEEKDAY`, `year_wrap` = 0, `day_inc_q` = 1. `leap_year` follows the reset year.
- Advance event sampled at edge N: new date visible after edge N. There is no extra pipeline latency.
- `year_wrap` is high for exactly the cycle after the wrapping edge, then returns to 0.
- A `day_increment` held high for K cycles produces exactly one advance.
- A `day_increment` edge that occurs during `set_en` or `preset` is consumed and lost; it is not deferred.
- Reset asserted mid-adjust overrides everything at that edge.

## Configuration
- `DATE_LEAP_YEAR_EN` defined: February length follows `leap_year`, and `leap_year` is driven as specified.
- `DATE_LEAP_YEAR_EN` undefined: February is always 28 days, `leap_year` is tied to 0, and the preset date still loads 28 Feb 2024, which then advances to 1 Mar.

## Structure
- Package `date_pkg`:
  - Weekday constants SUN..SAT.
  - Month constants JAN..DEC.
  - Preset constants (`PRESET_YEAR`/`MONTH`/`DAY`/`WDAY`).
  - Widths `YEAR_W` = 7, `MONTH_W` = 4, `DAY_W` = 5, `WDAY_W` = 3.
- Sub-module `days_in_month`: combinational lookup from (month, leap) to a 5-bit length. It is instanced twice: once for the current date, once for the post-adjust month/year used by the clamp.

## Test plan
- Reset with defaults; pulse `day_increment` at 31 Jan 2000 → 1 Feb 2000, weekday 2 (Tue).
- `preset`, then one pulse → 29 Feb 2024, `leap_year` = 1 with `DATE_LEAP_YEAR_EN`; 1 Mar 2024 without it.
- Adjust to 31 Dec 2099 (weekday 4), then one pulse → 1 Jan 2000, weekday 5, and `year_wrap` high for one cycle.
- Hold `day_increment` high for 5 cycles from 10 Mar → date becomes 11 Mar, with no further change.
- `set_en` with day 31, month 1, year 24, then `inc_month` for one cycle → month 2, day clamped to 29; a second `inc_month` → month 3, day stays 29.
- Assert `rst_n` = 0 while `set_en` and `inc_day` are high → next cycle shows reset values; raise `day_increment` the cycle `rst_n` returns high → no advance until a fresh rising edge.
